// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter that shares one mux tree and its destination register
// between NUM_REQ requesters, with a bounded ownership time.
module mux_share_arbiter #(
  parameter int unsigned SEL_BITS = 2,
  // Derived from SEL_BITS; must stay equal to 2**SEL_BITS.
  parameter int unsigned NUM_REQ  = 2**SEL_BITS,
  // Grant cycles per ownership while others wait; 0 disables the timeout.
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [SEL_BITS-1:0] sel,
  output logic                busy,
  output logic                xfer_en
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  // Last hold count value; the counter saturates here.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? HOLD_W'(0) : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [SEL_BITS-1:0] sel_d;
  logic                busy_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                win_vld;
  logic [SEL_BITS-1:0] win_idx;
  logic [SEL_BITS-1:0] cand;
  logic                others_req;
  logic                owner_rel;
  logic                owner_to;

  // First set request searching upward from ptr, wrapping at NUM_REQ-1.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + SEL_BITS'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Release and timeout conditions for the current owner.
  always_comb begin
    others_req = |(req & ~gnt);
    owner_rel  = ~req[sel];
    owner_to   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_OWN;
          gnt_d   = NUM_REQ'(1) << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_OWN: begin
        // Release takes priority; both paths lead to the same REL entry.
        if (owner_rel || owner_to) begin
          state_d = ST_REL;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel + SEL_BITS'(1);
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_REL: begin
        // sel is left alone so the mux output stays stable in the bubble.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Destination register enable: owner present and still requesting.
  assign xfer_en = (state_q == ST_OWN) & req[sel];

  // Structural invariants of the grant interface.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_gnt_busy    : assert property (@(posedge clk) disable iff (!rst) ((gnt != '0) == busy));
  a_sel_owner   : assert property (@(posedge clk) disable iff (!rst) busy |-> gnt[sel]);
  a_xfer_busy   : assert property (@(posedge clk) disable iff (!rst) xfer_en |-> busy);

endmodule
